// File: rtl/traffic_pkg.sv
// traffic_pkg: direction encoding and constants shared by the arbiter and the traffic controller
package traffic_pkg;
  localparam int NUM_DIRS = 4;
  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_t;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchroniser followed by a consecutive-mismatch debounce counter
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/traffic_request_arbiter.sv
// traffic_request_arbiter: debounced sensor requests granted round-robin over a valid/ready handshake
module traffic_request_arbiter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_DIRS-1:0] sensor_raw,
  input  logic                grant_ready,
  output logic                grant_valid,
  output dir_t                grant_dir,
  output logic [NUM_DIRS-1:0] pending,
  output logic [NUM_DIRS-1:0] sensor_db
);
  logic [NUM_DIRS-1:0] db_q, rise, clr;
  logic [1:0] rr_ptr;
  logic hs;
  function automatic dir_t rr_pick(input logic [NUM_DIRS-1:0] req, input logic [1:0] ptr);
    dir_t pick;
    pick = DIR_N;
    for (int i = NUM_DIRS - 1; i >= 0; i--)
      if (req[ptr + 2'(i)]) pick = dir_t'(ptr + 2'(i));
    return pick;
  endfunction
  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_db
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .raw(sensor_raw[g]),
      .level(sensor_db[g])
    );
  end
  assign hs = grant_valid & grant_ready;
  assign rise = sensor_db & ~db_q;
  assign clr = hs ? NUM_DIRS'(1) << grant_dir : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
      pending <= '0;
      grant_valid <= 1'b0;
      grant_dir <= DIR_N;
      rr_ptr <= '0;
    end else begin
      db_q <= sensor_db;
      // a same-cycle rise re-arms the direction being granted
      pending <= (pending & ~clr) | rise;
      if (!grant_valid) begin
        if (|pending) begin
          grant_valid <= 1'b1;
          grant_dir <= rr_pick(pending, rr_ptr);
        end
      end else if (grant_ready) begin
        grant_valid <= 1'b0;
        rr_ptr <= 2'(grant_dir) + 2'd1;
      end
    end
  end
endmodule
